// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } rr_arb_state_e;

  // Next priority pointer after an accepted grant: one past the winner, wrapping to 0.
  function automatic int unsigned rr_arb_nxt_ptr(input int unsigned idx, input int unsigned req_n);
    return (idx + 1 >= req_n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_mask_ff.sv
// Find-first-set (LSb first) with one-hot, binary index and any outputs.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; pure function of the input vector.
module rr_mask_ff #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] oh,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from MSb down so the lowest set bit is the last assignment and wins.
  always_comb begin
    oh  = '0;
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        oh     = '0;
        oh[i]  = 1'b1;
        idx    = W'(i);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter issuing one registered grant at a time over valid/ready.
// Latency: 1 cycle from request seen in IDLE to gnt_vld; back-to-back grants at one per cycle.
// Backpressure: gnt_rdy=0 holds the grant (sticky); priority rotates only on accept.
// Optional macro RR_ARB_LOCK_EN adds gnt_lock, which keeps priority on the current winner.
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int REQ_N = 8,
  localparam int IDX_W = $clog2(REQ_N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_N-1:0] req,
  input  logic             gnt_rdy,
`ifdef RR_ARB_LOCK_EN
  input  logic             gnt_lock,
`endif
  output logic             gnt_vld,
  output logic [REQ_N-1:0] gnt_oh,
  output logic [IDX_W-1:0] gnt_idx
);

  rr_arb_state_e    state;
  logic [IDX_W-1:0] ptr;

  logic             accept;
  logic [IDX_W-1:0] adv_ptr;
  logic [IDX_W-1:0] nxt_ptr;
  logic [IDX_W-1:0] arb_ptr;
  logic [REQ_N-1:0] hi_mask;
  logic [REQ_N-1:0] hi_req;

  logic [REQ_N-1:0] hi_oh;
  logic [IDX_W-1:0] hi_idx;
  logic             hi_any;
  logic [REQ_N-1:0] lo_oh;
  logic [IDX_W-1:0] lo_idx;
  logic             lo_any;

  logic [REQ_N-1:0] win_oh;
  logic [IDX_W-1:0] win_idx;

  assign accept  = gnt_vld & gnt_rdy;
  assign adv_ptr = IDX_W'(rr_arb_nxt_ptr(32'(gnt_idx), REQ_N));

`ifdef RR_ARB_LOCK_EN
  // A locked accept keeps the current winner at top priority for burst continuation.
  assign nxt_ptr = gnt_lock ? gnt_idx : adv_ptr;
`else
  assign nxt_ptr = adv_ptr;
`endif

  // On accept the re-arbitration already sees the rotated pointer.
  assign arb_ptr = accept ? nxt_ptr : ptr;
  assign hi_mask = ~((REQ_N'(1) << arb_ptr) - REQ_N'(1));
  assign hi_req  = req & hi_mask;

  rr_mask_ff #(.N(REQ_N), .W(IDX_W)) u_ff_hi (
    .vec (hi_req),
    .oh  (hi_oh),
    .idx (hi_idx),
    .any (hi_any)
  );

  rr_mask_ff #(.N(REQ_N), .W(IDX_W)) u_ff_lo (
    .vec (req),
    .oh  (lo_oh),
    .idx (lo_idx),
    .any (lo_any)
  );

  assign win_oh  = hi_any ? hi_oh  : lo_oh;
  assign win_idx = hi_any ? hi_idx : lo_idx;

  // State, pointer and grant registers; the grant only changes on entry or accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_vld <= 1'b0;
      gnt_oh  <= '0;
      gnt_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lo_any) begin
            gnt_oh  <= win_oh;
            gnt_idx <= win_idx;
            gnt_vld <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (gnt_rdy) begin
            ptr <= nxt_ptr;
            if (lo_any) begin
              gnt_oh  <= win_oh;
              gnt_idx <= win_idx;
            end else begin
              gnt_vld <= 1'b0;
              gnt_oh  <= '0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          gnt_vld <= 1'b0;
          gnt_oh  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter with REQ_N=4.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: gnt_rdy is driven by the scenarios to stall and release grants.
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       gnt_rdy;
  logic       gnt_vld;
  logic [3:0] gnt_oh;
  logic [1:0] gnt_idx;
`ifdef RR_ARB_LOCK_EN
  logic       gnt_lock;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  rr_arbiter #(.REQ_N(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt_rdy (gnt_rdy),
`ifdef RR_ARB_LOCK_EN
    .gnt_lock(gnt_lock),
`endif
    .gnt_vld (gnt_vld),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    req     = 4'b0000;
    gnt_rdy = 1'b0;
    step();
    step();
    checks++;
    if (gnt_vld !== 1'b0 || gnt_oh !== 4'b0000 || gnt_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_state vld=%b oh=%b idx=%0d expected 0 0000 0", gnt_vld, gnt_oh, gnt_idx);
    end
    rst_n   = 1'b1;
    gnt_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (gnt_vld !== 1'b0 || gnt_oh !== 4'b0000) begin
        errors++;
        $display("FAIL idle_no_req cycle %0d vld=%b oh=%b expected 0 0000", c, gnt_vld, gnt_oh);
      end
    end
  endtask

  task automatic test_rotate();
    int e;
    exp_q = {0, 1, 2, 3, 0};
    req     = 4'b1111;
    gnt_rdy = 1'b1;
    step();
    checks++;
    if (gnt_vld !== 1'b1) begin
      errors++;
      $display("FAIL rotate_latency vld=%b expected 1", gnt_vld);
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (gnt_vld && gnt_rdy) begin
        e = exp_q.pop_front();
        checks++;
        if (gnt_idx !== 2'(e) || gnt_oh !== 4'(1 << e)) begin
          errors++;
          $display("FAIL rotate_grant idx=%0d oh=%b expected %0d %b", gnt_idx, gnt_oh, e, 4'(1 << e));
        end
      end
      if (exp_q.size() == 0) req = 4'b0000;
      step();
    end
    checks++;
    if (exp_q.size() != 0 || gnt_vld !== 1'b0 || gnt_oh !== 4'b0000) begin
      errors++;
      $display("FAIL rotate_end left=%0d vld=%b oh=%b expected 0 0 0000", exp_q.size(), gnt_vld, gnt_oh);
    end
  endtask

  task automatic test_stall();
    int e;
    exp_q.push_back(1);
    req     = 4'b1010;
    gnt_rdy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (gnt_vld !== 1'b1 || gnt_idx !== 2'd1 || gnt_oh !== 4'b0010) begin
        errors++;
        $display("FAIL stall_hold cycle %0d vld=%b idx=%0d oh=%b expected 1 1 0010", c, gnt_vld, gnt_idx, gnt_oh);
      end
    end
    req = 4'b0000;
    step();
    checks++;
    if (gnt_vld !== 1'b1 || gnt_idx !== 2'd1) begin
      errors++;
      $display("FAIL stall_sticky vld=%b idx=%0d expected 1 1", gnt_vld, gnt_idx);
    end
    gnt_rdy = 1'b1;
    if (gnt_vld && gnt_rdy) begin
      e = exp_q.pop_front();
      checks++;
      if (gnt_idx !== 2'(e) || gnt_oh !== 4'(1 << e)) begin
        errors++;
        $display("FAIL stall_accept idx=%0d oh=%b expected %0d %b", gnt_idx, gnt_oh, e, 4'(1 << e));
      end
    end
    step();
    checks++;
    if (gnt_vld !== 1'b0 || gnt_oh !== 4'b0000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_release vld=%b oh=%b left=%0d expected 0 0000 0", gnt_vld, gnt_oh, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int e;
    exp_q = {2, 3, 0};
    req     = 4'b1111;
    gnt_rdy = 1'b1;
    step();
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (gnt_vld && gnt_rdy) begin
        e = exp_q.pop_front();
        checks++;
        if (gnt_idx !== 2'(e) || gnt_oh !== 4'(1 << e)) begin
          errors++;
          $display("FAIL wrap_grant idx=%0d oh=%b expected %0d %b", gnt_idx, gnt_oh, e, 4'(1 << e));
        end
      end
      if (exp_q.size() == 2) req = 4'b1001;
      if (exp_q.size() == 0) req = 4'b0000;
      step();
    end
    checks++;
    if (exp_q.size() != 0 || gnt_vld !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end left=%0d vld=%b expected 0 0", exp_q.size(), gnt_vld);
    end
  endtask

  task automatic test_reset_mid_grant();
    req     = 4'b0100;
    gnt_rdy = 1'b1;
    step();
    checks++;
    if (gnt_vld !== 1'b1 || gnt_idx !== 2'd2) begin
      errors++;
      $display("FAIL rmid_first vld=%b idx=%0d expected 1 2", gnt_vld, gnt_idx);
    end
    req = 4'b0110;
    step();
    gnt_rdy = 1'b0;
    checks++;
    if (gnt_vld !== 1'b1 || gnt_idx !== 2'd1) begin
      errors++;
      $display("FAIL rmid_second vld=%b idx=%0d expected 1 1", gnt_vld, gnt_idx);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (gnt_vld !== 1'b0 || gnt_oh !== 4'b0000 || gnt_idx !== 2'd0) begin
      errors++;
      $display("FAIL rmid_cleared vld=%b oh=%b idx=%0d expected 0 0000 0", gnt_vld, gnt_oh, gnt_idx);
    end
    rst_n = 1'b1;
    req   = 4'b1010;
    step();
    checks++;
    if (gnt_vld !== 1'b1 || gnt_idx !== 2'd1 || gnt_oh !== 4'b0010) begin
      errors++;
      $display("FAIL rmid_after vld=%b idx=%0d oh=%b expected 1 1 0010", gnt_vld, gnt_idx, gnt_oh);
    end
  endtask

`ifdef RR_ARB_LOCK_EN
  task automatic test_lock();
    int e;
    int n = 0;
    exp_q = {1, 1, 1, 1, 2};
    req      = 4'b0110;
    gnt_rdy  = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (gnt_vld && gnt_rdy) begin
        e = exp_q.pop_front();
        n++;
        checks++;
        if (gnt_idx !== 2'(e) || gnt_oh !== 4'(1 << e)) begin
          errors++;
          $display("FAIL lock_grant beat %0d idx=%0d oh=%b expected %0d %b", n, gnt_idx, gnt_oh, e, 4'(1 << e));
        end
      end
      gnt_lock = (n <= 3);
      if (exp_q.size() == 0) req = 4'b0000;
      step();
    end
    gnt_lock = 1'b0;
    checks++;
    if (exp_q.size() != 0 || gnt_vld !== 1'b0) begin
      errors++;
      $display("FAIL lock_end left=%0d vld=%b expected 0 0", exp_q.size(), gnt_vld);
    end
  endtask
`else
  task automatic test_advance();
    int e;
    exp_q = {1, 2, 1, 2};
    req     = 4'b0110;
    gnt_rdy = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (gnt_vld && gnt_rdy) begin
        e = exp_q.pop_front();
        checks++;
        if (gnt_idx !== 2'(e) || gnt_oh !== 4'(1 << e)) begin
          errors++;
          $display("FAIL advance_grant idx=%0d oh=%b expected %0d %b", gnt_idx, gnt_oh, e, 4'(1 << e));
        end
      end
      if (exp_q.size() == 0) req = 4'b0000;
      step();
    end
    checks++;
    if (exp_q.size() != 0 || gnt_vld !== 1'b0) begin
      errors++;
      $display("FAIL advance_end left=%0d vld=%b expected 0 0", exp_q.size(), gnt_vld);
    end
  endtask
`endif

  initial begin
`ifdef RR_ARB_LOCK_EN
    gnt_lock = 1'b0;
`endif
    test_reset();
    test_rotate();
    test_stall();
    test_wrap();
    test_reset_mid_grant();
`ifdef RR_ARB_LOCK_EN
    test_lock();
`else
    test_advance();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
